// File: rtl/aes_block_sequencer.sv
// AES job sequencer: key init, 4-beat block gather, core start/wait, 4-beat drain. Optional AES_SEQ_PERF_CNT_EN adds perf_cycles_o.
// Latency: KEY_WAIT->in_ready_o 1 cycle, core_done_i->out_valid_o 1 cycle, done_o 2 cycles after start for an empty job.
// Backpressure: input taken only in LOAD on valid; output word held stable in SEND until out_ready_i.
module aes_block_sequencer #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 128,
    parameter int KEY_W   = 256
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               start_i,
    input  logic [31:0]        data_size_i,
    input  logic [KEY_W-1:0]   key_i,
    input  logic               key_mode_i,
    input  logic               enc_dec_i,
    input  logic [WORD_W-1:0]  in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [WORD_W-1:0]  out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               core_init_key_o,
    output logic [KEY_W-1:0]   core_key_o,
    output logic               core_key_mode_o,
    output logic               core_enc_dec_o,
    output logic               core_start_o,
    output logic [BLOCK_W-1:0] core_block_o,
    input  logic               core_ready_i,
    input  logic               core_done_i,
    input  logic [BLOCK_W-1:0] core_result_i,
    output logic               busy_o,
    output logic               done_o
`ifdef AES_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]        perf_cycles_o
`endif
);

    typedef enum logic [2:0] {
        IDLE, INIT_KEY, KEY_WAIT, LOAD, START, WAIT_CORE, SEND, FINISHED
    } state_e;

    state_e             state_q;
    logic [1:0]         beat_q;
    logic [28:0]        blk_cnt_q;
    logic [28:0]        nblk_q;
    logic [KEY_W-1:0]   key_q;
    logic               key_mode_q;
    logic               enc_dec_q;
    logic [BLOCK_W-1:0] block_q;
    logic [BLOCK_W-1:0] out_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               init_key_q;
    logic               start_q;
    logic               busy_q;
    logic               done_q;
    logic [28:0]        blk_cnt_d;
`ifdef AES_SEQ_PERF_CNT_EN
    logic [31:0]        perf_q;
`endif

    assign blk_cnt_d = blk_cnt_q + 29'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            blk_cnt_q   <= '0;
            nblk_q      <= '0;
            key_q       <= '0;
            key_mode_q  <= 1'b0;
            enc_dec_q   <= 1'b0;
            block_q     <= '0;
            out_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            init_key_q  <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef AES_SEQ_PERF_CNT_EN
            perf_q      <= '0;
`endif
        end else if (clear_i) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            blk_cnt_q   <= '0;
            nblk_q      <= '0;
            key_q       <= '0;
            key_mode_q  <= 1'b0;
            enc_dec_q   <= 1'b0;
            block_q     <= '0;
            out_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            init_key_q  <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef AES_SEQ_PERF_CNT_EN
            perf_q      <= '0;
`endif
        end else begin
            init_key_q <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
`ifdef AES_SEQ_PERF_CNT_EN
            if (state_q == IDLE && start_i) begin
                perf_q <= '0;
            end else if (state_q != IDLE && perf_q != 32'hFFFF_FFFF) begin
                perf_q <= perf_q + 32'd1;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        // 33-bit sum keeps sizes near 2^32 from wrapping to zero blocks
                        nblk_q     <= 29'(({1'b0, data_size_i} + 33'd15) >> 4);
                        blk_cnt_q  <= '0;
                        beat_q     <= '0;
                        key_q      <= key_mode_i ? key_i
                                                 : {key_i[KEY_W-1:KEY_W/2], {(KEY_W/2){1'b0}}};
                        key_mode_q <= key_mode_i;
                        enc_dec_q  <= enc_dec_i;
                        busy_q     <= 1'b1;
                        if (data_size_i == 32'd0) begin
                            state_q <= FINISHED;
                        end else begin
                            state_q    <= INIT_KEY;
                            init_key_q <= 1'b1;
                        end
                    end
                end
                INIT_KEY: state_q <= KEY_WAIT;
                KEY_WAIT: begin
                    if (core_ready_i) begin
                        state_q    <= LOAD;
                        in_ready_q <= 1'b1;
                        beat_q     <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid_i) begin
                        block_q <= {block_q[BLOCK_W-WORD_W-1:0], in_data_i};
                        beat_q  <= beat_q + 2'd1;
                        if (beat_q == 2'd3) begin
                            in_ready_q <= 1'b0;
                            start_q    <= 1'b1;
                            state_q    <= START;
                        end
                    end
                end
                START: state_q <= WAIT_CORE;
                WAIT_CORE: begin
                    if (core_done_i) begin
                        out_q       <= core_result_i;
                        out_valid_q <= 1'b1;
                        beat_q      <= '0;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready_i) begin
                        out_q  <= {out_q[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
                        beat_q <= beat_q + 2'd1;
                        if (beat_q == 2'd3) begin
                            out_valid_q <= 1'b0;
                            blk_cnt_q   <= blk_cnt_d;
                            if (blk_cnt_d == nblk_q) begin
                                state_q <= FINISHED;
                            end else begin
                                state_q    <= LOAD;
                                in_ready_q <= 1'b1;
                            end
                        end
                    end
                end
                FINISHED: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o      = in_ready_q;
    assign out_valid_o     = out_valid_q;
    assign out_data_o      = out_q[BLOCK_W-1 -: WORD_W];
    assign core_init_key_o = init_key_q;
    assign core_key_o      = key_q;
    assign core_key_mode_o = key_mode_q;
    assign core_enc_dec_o  = enc_dec_q;
    assign core_start_o    = start_q;
    assign core_block_o    = block_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
`ifdef AES_SEQ_PERF_CNT_EN
    assign perf_cycles_o   = perf_q;
`endif

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Bench for aes_block_sequencer: a stub AES core plus a block-level model of expected streams and pulse counts.
module tb_aes_block_sequencer;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam int BUDGET = 3000;

    logic         clk_i = 1'b0;
    logic         rst_ni, clear_i, start_i, key_mode_i, enc_dec_i;
    logic [31:0]  data_size_i, in_data_i, out_data_o;
    logic [255:0] key_i, core_key_o;
    logic         in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic         core_init_key_o, core_key_mode_o, core_enc_dec_o, core_start_o;
    logic [127:0] core_block_o, core_result_i;
    logic         core_ready_i, core_done_i, busy_o, done_o;
`ifdef AES_SEQ_PERF_CNT_EN
    logic [31:0]  perf_cycles_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0]  in_words[$];
    logic [31:0]  exp_out[$];
    logic [127:0] exp_blk[$];
    logic [31:0]  got_out[$];
    logic [127:0] got_blk[$];
    int n_init, n_start, n_done, n_in, done_cyc, viol_stable, viol_overlap;

    always #5 clk_i = ~clk_i;

    aes_block_sequencer dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .data_size_i(data_size_i), .key_i(key_i), .key_mode_i(key_mode_i), .enc_dec_i(enc_dec_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .core_init_key_o(core_init_key_o), .core_key_o(core_key_o), .core_key_mode_o(core_key_mode_o),
        .core_enc_dec_o(core_enc_dec_o), .core_start_o(core_start_o), .core_block_o(core_block_o),
        .core_ready_i(core_ready_i), .core_done_i(core_done_i), .core_result_i(core_result_i),
        .busy_o(busy_o), .done_o(done_o)
`ifdef AES_SEQ_PERF_CNT_EN
        , .perf_cycles_o(perf_cycles_o)
`endif
    );

    // Stand-in for the AES core: real FIPS-197 vector, otherwise a key-dependent scramble.
    function automatic logic [127:0] core_fn(input logic [127:0] blk, input logic [255:0] ck, input logic enc);
        if (enc && ck == {FIPS_KEY, 128'd0} && blk == FIPS_PT) return FIPS_CT;
        return {blk[95:0], blk[127:96]} ^ ck[255:128] ^ ck[127:0] ^ {128{enc}};
    endfunction

    function automatic logic [255:0] eff_key(input logic [255:0] k, input logic mode);
        return mode ? k : {k[255:128], 128'd0};
    endfunction

    function automatic int nblocks(input logic [31:0] size);
        longint s;
        s = longint'(size);
        return int'((s + 15) / 16);
    endfunction

    task automatic make_words(input logic [31:0] size);
        in_words.delete();
        for (int i = 0; i < nblocks(size) * 4; i++) in_words.push_back($urandom);
    endtask

    task automatic build_expected(input logic [31:0] size, input logic [255:0] k, input logic mode, input logic enc);
        logic [127:0] b, r;
        exp_out.delete();
        exp_blk.delete();
        for (int i = 0; i < nblocks(size); i++) begin
            b = {in_words[4*i], in_words[4*i+1], in_words[4*i+2], in_words[4*i+3]};
            exp_blk.push_back(b);
            r = core_fn(b, eff_key(k, mode), enc);
            exp_out.push_back(r[127:96]);
            exp_out.push_back(r[95:64]);
            exp_out.push_back(r[63:32]);
            exp_out.push_back(r[31:0]);
        end
    endtask

    // Runs one job: drives inputs after each rising edge, samples everything on the falling edge.
    task automatic run_job(input logic [31:0] size, input logic [255:0] k, input logic mode, input logic enc,
                           input int in_gap, input int out_gap, input int stall_at,
                           input int abort_kind, input bit start_in_load);
        int in_idx = 0, key_cnt = 0, core_cnt = 0, stall_left = 0;
        bit stalled = 0, sil_done = 0, prev_stall = 0, hs_in, hs_out;
        logic [31:0] prev_dat = '0;
        logic [127:0] core_res = '0;
        got_out.delete(); got_blk.delete();
        n_init = 0; n_start = 0; n_done = 0; n_in = 0; done_cyc = -1; viol_stable = 0; viol_overlap = 0;
        @(posedge clk_i); #1;
        data_size_i = size; key_i = k; key_mode_i = mode; enc_dec_i = enc; start_i = 1'b1;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(negedge clk_i);
            hs_in  = in_valid_i && in_ready_o;
            hs_out = out_valid_o && out_ready_i;
            if (in_ready_o && out_valid_o) viol_overlap++;
            if (prev_stall && (!out_valid_o || out_data_o !== prev_dat)) viol_stable++;
            prev_stall = out_valid_o && !out_ready_i;
            prev_dat   = out_data_o;
            if (hs_out) got_out.push_back(out_data_o);
            if (hs_in) begin in_idx++; n_in++; end
            if (core_init_key_o) n_init++;
            if (core_start_o) begin n_start++; got_blk.push_back(core_block_o); end
            if (done_o) begin n_done++; done_cyc = cyc; end
            if (n_done > 0 && cyc > done_cyc + 3) break;
            @(posedge clk_i); #1;
            start_i = 1'b0;
            if (start_in_load && !sil_done && in_ready_o && n_in >= 1) begin
                start_i = 1'b1; data_size_i = 32'd16; sil_done = 1;
            end
            if (core_init_key_o) begin
                core_ready_i = 1'b0; key_cnt = $urandom_range(1, 4);
            end else if (key_cnt > 0) begin
                key_cnt--;
                if (key_cnt == 0) core_ready_i = 1'b1;
            end
            core_done_i = 1'b0;
            core_result_i = {$urandom, $urandom, $urandom, $urandom};
            if (core_start_o) begin
                core_cnt = $urandom_range(2, 5);
                core_res = core_fn(core_block_o, core_key_o, core_enc_dec_o);
            end else if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin core_done_i = 1'b1; core_result_i = core_res; end
            end
            if (abort_kind != 0 && core_cnt > 0 && !core_start_o) begin
                core_done_i = 1'b0; in_valid_i = 1'b0;
                if (abort_kind == 1) rst_ni = 1'b0;
                else begin clear_i = 1'b1; @(posedge clk_i); #1; clear_i = 1'b0; end
                break;
            end
            if (in_idx < in_words.size() && $urandom_range(0, 99) >= in_gap) begin
                in_valid_i = 1'b1; in_data_i = in_words[in_idx];
            end else begin
                in_valid_i = 1'b0; in_data_i = $urandom;
            end
            if (stall_left > 0) begin
                out_ready_i = 1'b0; stall_left--;
            end else if (stall_at >= 0 && !stalled && got_out.size() == stall_at) begin
                out_ready_i = 1'b0; stall_left = 4; stalled = 1;
            end else begin
                out_ready_i = ($urandom_range(0, 99) >= out_gap);
            end
        end
        start_i = 1'b0; in_valid_i = 1'b0; core_done_i = 1'b0; core_ready_i = 1'b1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; clear_i = 0; start_i = 0; data_size_i = 0; key_i = '0; key_mode_i = 0; enc_dec_i = 0;
        in_data_i = 0; in_valid_i = 0; out_ready_i = 0; core_ready_i = 1; core_done_i = 0; core_result_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if ({busy_o, done_o, in_ready_o, out_valid_o} !== 4'b0) begin errors++;
            $display("FAIL reset_flags: got %b expected 0000", {busy_o, done_o, in_ready_o, out_valid_o}); end
        checks++; if ({core_start_o, core_init_key_o, core_key_mode_o, core_enc_dec_o} !== 4'b0) begin errors++;
            $display("FAIL reset_core_ctl: got %b expected 0000", {core_start_o, core_init_key_o, core_key_mode_o, core_enc_dec_o}); end
        checks++; if (core_key_o !== '0) begin errors++; $display("FAIL reset_key: got %h expected 0", core_key_o); end
        checks++; if (core_block_o !== '0 || out_data_o !== '0) begin errors++;
            $display("FAIL reset_data: got block %h out %h expected 0", core_block_o, out_data_o); end
        @(negedge clk_i); rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++; if (busy_o !== 1'b0 || in_ready_o !== 1'b0) begin errors++;
            $display("FAIL reset_idle: got busy %b in_ready %b expected 0 0", busy_o, in_ready_o); end
    endtask

    task automatic test_fips;
        logic [255:0] k;
        logic [127:0] ct;
        ct = FIPS_CT;
        k = {FIPS_KEY, $urandom, $urandom, $urandom, $urandom};
        in_words.delete();
        in_words.push_back(32'h00112233); in_words.push_back(32'h44556677);
        in_words.push_back(32'h8899aabb); in_words.push_back(32'hccddeeff);
        run_job(32'd16, k, 1'b0, 1'b1, 20, 0, -1, 0, 0);
        checks++; if (got_out.size() != 4) begin errors++; $display("FAIL fips_count: got %0d expected 4", got_out.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got_out[i] !== ct[127-32*i -: 32]) begin errors++;
                $display("FAIL fips_word%0d: got %h expected %h", i, got_out[i], ct[127-32*i -: 32]); end
        end
        checks++; if (n_done != 1) begin errors++; $display("FAIL fips_done: got %0d expected 1", n_done); end
        checks++; if (core_key_o !== {FIPS_KEY, 128'd0}) begin errors++;
            $display("FAIL fips_key: got %h expected %h", core_key_o, {FIPS_KEY, 128'd0}); end
        checks++; if (n_init != 1 || n_start != 1) begin errors++;
            $display("FAIL fips_pulses: got init %0d start %0d expected 1 1", n_init, n_start); end
    endtask

    task automatic test_zero_size;
        in_words.delete();
        run_job(32'd0, {8{$urandom}}, 1'b1, 1'b0, 0, 0, -1, 0, 0);
        checks++; if (done_cyc != 2) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 2", done_cyc); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", n_done); end
        checks++; if (n_init != 0 || n_start != 0) begin errors++;
            $display("FAIL zero_core_pulses: got init %0d start %0d expected 0 0", n_init, n_start); end
        checks++; if (got_out.size() != 0 || n_in != 0) begin errors++;
            $display("FAIL zero_stream: got out %0d in %0d expected 0 0", got_out.size(), n_in); end
    endtask

    task automatic test_multi_block;
        logic [255:0] k;
        k = {8{$urandom}};
        make_words(32'd33);
        build_expected(32'd33, k, 1'b1, 1'b0);
        run_job(32'd33, k, 1'b1, 1'b0, 30, 30, -1, 0, 0);
        checks++; if (n_in != 12) begin errors++; $display("FAIL multi_in_beats: got %0d expected 12", n_in); end
        checks++; if (got_out.size() != 12) begin errors++; $display("FAIL multi_out_beats: got %0d expected 12", got_out.size()); end
        for (int i = 0; i < 12; i++) begin
            checks++; if (got_out[i] !== exp_out[i]) begin errors++;
                $display("FAIL multi_word%0d: got %h expected %h", i, got_out[i], exp_out[i]); end
        end
        checks++; if (n_start != 3 || n_done != 1) begin errors++;
            $display("FAIL multi_pulses: got start %0d done %0d expected 3 1", n_start, n_done); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (got_blk[i] !== exp_blk[i]) begin errors++;
                $display("FAIL multi_block%0d: got %h expected %h", i, got_blk[i], exp_blk[i]); end
        end
        checks++; if (viol_overlap != 0) begin errors++; $display("FAIL multi_overlap: got %0d expected 0", viol_overlap); end
        checks++; if (core_key_o !== k || core_key_mode_o !== 1'b1 || core_enc_dec_o !== 1'b0) begin errors++;
            $display("FAIL multi_cfg: got key %h mode %b enc %b", core_key_o, core_key_mode_o, core_enc_dec_o); end
    endtask

    task automatic test_backpressure;
        logic [255:0] k;
        k = {8{$urandom}};
        make_words(32'd32);
        build_expected(32'd32, k, 1'b0, 1'b1);
        run_job(32'd32, k, 1'b0, 1'b1, 0, 0, 2, 0, 0);
        checks++; if (viol_stable != 0) begin errors++; $display("FAIL bp_stable: got %0d violations expected 0", viol_stable); end
        checks++; if (got_out.size() != 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", got_out.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (got_out[i] !== exp_out[i]) begin errors++;
                $display("FAIL bp_word%0d: got %h expected %h", i, got_out[i], exp_out[i]); end
        end
    endtask

    task automatic test_abort(input int kind);
        logic [255:0] k;
        k = {8{$urandom}};
        make_words(32'd48);
        run_job(32'd48, k, 1'b1, 1'b1, 10, 10, -1, kind, 0);
        #1;
        checks++; if ({busy_o, done_o, in_ready_o, out_valid_o, core_start_o, core_init_key_o} !== 6'b0) begin errors++;
            $display("FAIL abort%0d_flags: got %b expected 000000", kind,
                     {busy_o, done_o, in_ready_o, out_valid_o, core_start_o, core_init_key_o}); end
        checks++; if (core_key_o !== '0 || core_block_o !== '0 || out_data_o !== '0) begin errors++;
            $display("FAIL abort%0d_regs: got key %h block %h out %h expected 0", kind, core_key_o, core_block_o, out_data_o); end
        @(negedge clk_i); rst_ni = 1'b1;
        n_done = 0;
        repeat (5) begin @(negedge clk_i); if (done_o) n_done++; end
        checks++; if (n_done != 0) begin errors++; $display("FAIL abort%0d_no_done: got %0d expected 0", kind, n_done); end
        k = {8{$urandom}};
        make_words(32'd16);
        build_expected(32'd16, k, 1'b0, 1'b0);
        run_job(32'd16, k, 1'b0, 1'b0, 20, 20, -1, 0, 0);
        checks++; if (got_out.size() != 4 || n_done != 1) begin errors++;
            $display("FAIL abort%0d_next_job: got %0d words %0d done expected 4 1", kind, got_out.size(), n_done); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got_out[i] !== exp_out[i]) begin errors++;
                $display("FAIL abort%0d_word%0d: got %h expected %h", kind, i, got_out[i], exp_out[i]); end
        end
    endtask

    task automatic test_start_in_load;
        logic [255:0] k;
        k = {8{$urandom}};
        make_words(32'd48);
        build_expected(32'd48, k, 1'b1, 1'b1);
        run_job(32'd48, k, 1'b1, 1'b1, 60, 0, -1, 0, 1);
        checks++; if (n_start != 3 || n_init != 1 || n_done != 1) begin errors++;
            $display("FAIL sil_pulses: got start %0d init %0d done %0d expected 3 1 1", n_start, n_init, n_done); end
        checks++; if (got_out.size() != 12) begin errors++; $display("FAIL sil_count: got %0d expected 12", got_out.size()); end
        for (int i = 0; i < 12; i++) begin
            checks++; if (got_out[i] !== exp_out[i]) begin errors++;
                $display("FAIL sil_word%0d: got %h expected %h", i, got_out[i], exp_out[i]); end
        end
    endtask

    task automatic test_random_jobs;
        logic [255:0] k;
        logic [31:0] sz;
        logic m, e;
        for (int j = 0; j < 4; j++) begin
            k = {8{$urandom}}; sz = $urandom_range(1, 80); m = $urandom_range(0, 1); e = $urandom_range(0, 1);
            make_words(sz);
            build_expected(sz, k, m, e);
            run_job(sz, k, m, e, 40, 40, -1, 0, 0);
            checks++; if (got_out.size() != exp_out.size() || n_done != 1 || n_start != nblocks(sz)) begin errors++;
                $display("FAIL rand%0d_shape: size %0d got %0d words %0d done %0d starts expected %0d 1 %0d",
                         j, sz, got_out.size(), n_done, n_start, exp_out.size(), nblocks(sz)); end
            for (int i = 0; i < exp_out.size(); i++) begin
                checks++; if (got_out[i] !== exp_out[i]) begin errors++;
                    $display("FAIL rand%0d_word%0d: got %h expected %h", j, i, got_out[i], exp_out[i]); end
            end
            checks++; if (core_key_o !== eff_key(k, m)) begin errors++;
                $display("FAIL rand%0d_key: got %h expected %h", j, core_key_o, eff_key(k, m)); end
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_zero_size();
        test_multi_block();
        test_backpressure();
        test_abort(1);
        test_abort(2);
        test_start_in_load();
        test_random_jobs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
